crc_arbiter: RTL
================

Name: crc_arbiter

Overview:
Shares a single CRC core among NUM_REQ requesters using round-robin arbitration. Each grant follows the same sequence: latch the winning requester's word, pulse a start command to the core, wait for the core's done, then return the result tagged with the requester ID. A watchdog aborts jobs the core never completes. Sits between the requester fabric and the CRC core's control/data_in/enable/result/done/busy interface.

Parameters:
- DATA_WIDTH, 32, width of request data and CRC result.
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, $clog2(NUM_REQ), width of the requester index.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort (>=2).
- TO_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until req_ready is seen.
- req_data  in  NUM_REQ*DATA_WIDTH  packed request words; slice i = requester i.
- req_ready  out  NUM_REQ  one-hot one-cycle accept pulse.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  ID_WIDTH  index of the requester being answered.
- rsp_data  out  DATA_WIDTH  CRC result; zero when rsp_err=1.
- rsp_err  out  1  timeout flag qualified by rsp_valid.
- core_control  out  2  2'b01 = start, 2'b00 = hold.
- core_enable  out  1  core enable.
- core_data  out  DATA_WIDTH  word presented to the core.
- core_result  in  DATA_WIDTH  core result, valid with core_done.
- core_done  in  1  core completion pulse.
- core_busy  in  1  core busy.

Behaviour:
- Reset (asynchronous): state=IDLE, rr_ptr=0, all outputs 0, core_control=2'b00, latched data/ID/counter cleared. Reset mid-job abandons the job; no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP. Every output is a registered (Moore) output.
- IDLE:
  - If any req_valid is high and core_busy=0, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch the winner's ID and data slice, then go to ISSUE.
  - If core_busy=1, stay in IDLE and grant nothing.
- ISSUE (1 cycle):
  - req_ready[id]=1, core_control=2'b01, core_enable=1, core_data=latched word.
  - Watchdog counter cleared; next state WAIT.
  - core_done is ignored in ISSUE.
- WAIT:
  - core_control=2'b00; core_enable=1; core_data held.
  - Counter increments each cycle.
  - core_done=1: latch core_result, clear err, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without done: set err, force result to 0, go to RESP.
  - If done and timeout occur in the same cycle, done wins and err=0.
- RESP (1 cycle):
  - rsp_valid=1 with rsp_id, rsp_data, rsp_err; core_enable=0.
  - rr_ptr = id+1, wrapping NUM_REQ-1 -> 0. Next state IDLE.
- Handshake: the requester must hold req_valid/req_data until it samples req_ready=1, then deassert or present a new word. The arbiter does not sample req_valid outside IDLE, so there is no double grant.
- Job latency is 3 + W cycles from the IDLE grant edge, where W is the number of WAIT cycles. Back-to-back jobs therefore have at least one IDLE cycle between them.
- rsp_* outputs hold their values after RESP; only rsp_valid returns to 0.
- req_valid bits dropped before a grant are simply not granted; no error is raised.

Test Plan:
- Bench core model: returns data^32'hA5A5A5A5, done 5 cycles after start.
- Single request: req_valid=4'b0001, req_data[0]=32'h0089CADE.
  - Required: req_ready=4'b0001 for one cycle, core_control=2'b01 for one cycle.
  - Then rsp_valid with rsp_id=0, rsp_data=32'hA52C6F7B, rsp_err=0.
- Round-robin: all four req_valid held high continuously.
  - Required: grant order 0,1,2,3,0; each req_ready one-hot; no overlapping jobs.
- Wrap and skip: rr_ptr=3, req_valid=4'b0101.
  - Required: requester 0 granted next, then 2.
- Timeout: core model never asserts done, TIMEOUT_CYCLES=64.
  - Required: rsp_valid 64 WAIT cycles after ISSUE with rsp_err=1 and rsp_data=0.
  - The next request is served normally afterwards.
- core_busy=1 held for 10 cycles with req_valid=4'b0010.
  - Required: no req_ready during those cycles; grant to requester 1 in the first IDLE cycle after busy falls.
- reset_n pulsed low during WAIT.
  - Required: all outputs 0 immediately; no rsp_valid; a fresh request after release completes normally from rr_ptr=0.

Source files
------------

// File: rtl/crc_arbiter.sv
// Round-robin arbiter sharing one CRC core among NUM_REQ requesters.
// A watchdog aborts any job the core fails to finish within TIMEOUT_CYCLES.
module crc_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic [1:0]                    core_control,
  output logic                          core_enable,
  output logic [DATA_WIDTH-1:0]         core_data,
  input  logic [DATA_WIDTH-1:0]         core_result,
  input  logic                          core_done,
  input  logic                          core_busy
);

  localparam int IW1 = ID_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [TO_WIDTH-1:0]   r_cnt;
  logic [NUM_REQ-1:0]    r_req_ready;
  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic [1:0]            r_core_control;
  logic                  r_core_enable;
  logic [DATA_WIDTH-1:0] r_core_data;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_win;
  logic [IW1-1:0]        w_idx;
  logic [DATA_WIDTH-1:0] w_word;
  logic [NUM_REQ-1:0]    w_onehot;
  logic [ID_WIDTH-1:0]   w_next_ptr;

  // Search upward from the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + IW1'(k);
      if (w_idx >= IW1'(NUM_REQ)) w_idx = w_idx - IW1'(NUM_REQ);
      if (!w_found && req_valid[w_idx[ID_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[ID_WIDTH-1:0];
      end
    end
  end

  assign w_word     = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
  assign w_onehot   = NUM_REQ'(1) << w_win;
  assign w_next_ptr = (r_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_id + ID_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_id           <= '0;
      r_cnt          <= '0;
      r_req_ready    <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_data     <= '0;
      r_rsp_err      <= 1'b0;
      r_core_control <= 2'b00;
      r_core_enable  <= 1'b0;
      r_core_data    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found && !core_busy) begin
            r_id           <= w_win;
            r_core_data    <= w_word;
            r_req_ready    <= w_onehot;
            r_core_control <= 2'b01;
            r_core_enable  <= 1'b1;
            r_state        <= ISSUE;
          end
        end
        ISSUE: begin
          r_req_ready    <= '0;
          r_core_control <= 2'b00;
          r_cnt          <= '0;
          r_state        <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + TO_WIDTH'(1);
          // A done arriving on the watchdog's last cycle still counts as success.
          if (core_done || (r_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1))) begin
            r_rsp_data    <= core_done ? core_result : '0;
            r_rsp_err     <= !core_done;
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_id;
            r_core_enable <= 1'b0;
            r_state       <= RESP;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_rr_ptr    <= w_next_ptr;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;
  assign core_control = r_core_control;
  assign core_enable  = r_core_enable;
  assign core_data    = r_core_data;

endmodule
